// File: rtl/qram_access_sequencer.sv
// -----------------------------------------------------------------------------
// qram_access_sequencer
//
// Synchronous initiator for a column of single-bit QRAM cells. A host issues
// read/write requests over a valid/ready handshake; the sequencer decodes the
// address into one-hot WriteEdge/ReadEdge strobes, drives the shared
// inputData line with setup/hold margins around each strobe and samples the
// shared outputData line at the end of a read strobe. All strobe timing is
// owned here so cells never see overlapping or glitching edges.
//
// Handshakes (both request and response side):
//   A transfer happens on a rising Clock edge where valid and ready are both
//   high. ReqReady is high only in IDLE (and never during reset). Once
//   RspValid rises, RspData/RspErr stay constant until the edge that samples
//   RspReady high; RspReady while RspValid is low has no effect.
//
// Ports:
//   Clock, ResetN       single rising-edge clock, synchronous active-low reset
//   ReqValid/ReqReady   request handshake; ReqWrite, ReqAddr, ReqData payload
//   RspValid/RspReady   response handshake; RspData read bit, RspErr error
//   WriteEdge/ReadEdge  one-hot per-cell strobes (DEPTH wide)
//   inputData           shared write data line to cells
//   outputData          shared read data line from cells
//   DbgState            current FSM state, for observation only
//
// Optional feature macro: QRAM_READBACK_VERIFY_EN
//   When defined, every write is followed by a read cycle of the same address
//   and answered with the sampled bit; RspErr flags a readback mismatch.
//   When undefined, writes produce no response.
// -----------------------------------------------------------------------------
module qram_access_sequencer #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic              ReqData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic              RspData,
  output logic              RspErr,
  output logic [DEPTH-1:0]  WriteEdge,
  output logic [DEPTH-1:0]  ReadEdge,
  output logic              inputData,
  input  logic              outputData,
  output logic [2:0]        DbgState
);

  // Phase counter is sized for the longest of the three phases.
  localparam int MAX_CYC_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC    = (MAX_CYC_SP > HOLD_CYC) ? MAX_CYC_SP : HOLD_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  // Counter reload values: the counter counts down to zero, so a phase of N
  // cycles loads N-1 on entry.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  // One extra bit so DEPTH == 2**ADDR_W still fits.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Control / datapath registers
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;     // current SETUP/PULSE/HOLD block is a write
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               sample_q, sample_d;   // bit captured from outputData
`ifdef QRAM_READBACK_VERIFY_EN
  logic               wdata_q, wdata_d;     // written bit, kept for the readback compare
  logic               verify_q, verify_d;   // current read block is a write readback
`endif

  // Registered outputs
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DEPTH-1:0]   wedge_q, wedge_d;
  logic [DEPTH-1:0]   redge_q, redge_d;
  logic               in_data_q, in_data_d;

  // Address decode of the latched request
  logic               in_range;
  logic [DEPTH-1:0]   sel_vec;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

  // An out-of-range address decodes to no strobe at all; the timing still runs.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_range && (addr_q == ADDR_W'(i))) begin
        sel_vec[i] = 1'b1;
      end
    end
  end

  // ReqReady is the only combinational output; gating with ResetN keeps it
  // low for the whole reset window, not just after the first reset edge.
  assign ReqReady  = (state_q == ST_IDLE) && ResetN;

  assign RspValid  = rsp_valid_q;
  assign RspData   = rsp_data_q;
  assign RspErr    = rsp_err_q;
  assign WriteEdge = wedge_q;
  assign ReadEdge  = redge_q;
  assign inputData = in_data_q;
  assign DbgState  = state_q;

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that, once registered, they line up with that state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    sample_d    = sample_q;
`ifdef QRAM_READBACK_VERIFY_EN
    wdata_d     = wdata_q;
    verify_d    = verify_q;
`endif
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    wedge_d     = wedge_q;
    redge_d     = redge_q;
    in_data_d   = in_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          write_d   = ReqWrite;
          addr_d    = ReqAddr;
`ifdef QRAM_READBACK_VERIFY_EN
          wdata_d   = ReqData;
          verify_d  = 1'b0;
`endif
          // Reads keep the shared line low through the whole access.
          in_data_d = ReqWrite & ReqData;
          cnt_d     = SETUP_LOAD;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_q == '0) begin
          wedge_d = write_q ? sel_vec : '0;
          redge_d = write_q ? '0 : sel_vec;
          cnt_d   = PULSE_LOAD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_PULSE: begin
        if (cnt_q == '0) begin
          // Last strobe cycle: the addressed cell is still driving outputData.
          if (!write_q) begin
            sample_d = outputData;
          end
          wedge_d = '0;
          redge_d = '0;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            in_data_d = 1'b0;
`ifdef QRAM_READBACK_VERIFY_EN
            // Turn the write into a read of the same cell.
            write_d  = 1'b0;
            verify_d = 1'b1;
            cnt_d    = SETUP_LOAD;
            state_d  = ST_SETUP;
`else
            state_d  = ST_IDLE;
`endif
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = in_range & sample_q;
`ifdef QRAM_READBACK_VERIFY_EN
            rsp_err_d   = !in_range || (verify_q && (sample_q != wdata_q));
`else
            rsp_err_d   = !in_range;
`endif
            state_d     = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        wedge_d = '0;
        redge_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      sample_q    <= 1'b0;
`ifdef QRAM_READBACK_VERIFY_EN
      wdata_q     <= 1'b0;
      verify_q    <= 1'b0;
`endif
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      wedge_q     <= '0;
      redge_q     <= '0;
      in_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      sample_q    <= sample_d;
`ifdef QRAM_READBACK_VERIFY_EN
      wdata_q     <= wdata_d;
      verify_q    <= verify_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      wedge_q     <= wedge_d;
      redge_q     <= redge_d;
      in_data_q   <= in_data_d;
    end
  end

endmodule

// File: tb/tb_qram_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qram_access_sequencer
//
// Self-checking bench. A DEPTH=12 instance is used so addresses 12..15 are
// out of range. A small cell-array model answers strobes; expected strobe,
// line and response values come from phase arithmetic on SETUP/PULSE/HOLD
// and a reference memory, with expected responses queued in exp_q.
// -----------------------------------------------------------------------------
module tb_qram_access_sequencer;

  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;
  localparam int S      = 1;
  localparam int P      = 2;
  localparam int H      = 1;
  localparam int BLK    = S + P + H;
`ifdef QRAM_READBACK_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic              Clock = 1'b0;
  logic              ResetN;
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic              ReqData;
  logic              RspValid;
  logic              RspReady;
  logic              RspData;
  logic              RspErr;
  logic [DEPTH-1:0]  WriteEdge;
  logic [DEPTH-1:0]  ReadEdge;
  logic              inputData;
  logic              outputData;
  logic [2:0]        DbgState;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_q[$];          // expected {RspErr, RspData}
  bit         ref_mem[DEPTH];    // what each cell should hold
  bit         stuck = 1'b0;      // cell array read path stuck at 0

  // ---------------- clock ----------------
  always #5 Clock = ~Clock;

  qram_access_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .WriteEdge(WriteEdge), .ReadEdge(ReadEdge),
    .inputData(inputData), .outputData(outputData), .DbgState(DbgState)
  );

  // ---------------- cell array model ----------------
  logic [DEPTH-1:0] cell_mem = '0;

  always @(posedge Clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (WriteEdge[i]) cell_mem[i] <= inputData;
    end
  end

  always_comb begin
    logic v;
    v = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReadEdge[i] && cell_mem[i]) v = 1'b1;
    end
    outputData = stuck ? 1'b0 : v;
  end

  // ---------------- driver: one full transaction ----------------
  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] addr, input bit data,
                        input int hold_in, input bit early);
    bit               in_rng;
    logic [DEPTH-1:0] oh;
    logic [DEPTH-1:0] exp_we, exp_re;
    logic             exp_in;
    logic [1:0]       exp;
    bit               samp;
    int               busy, hold_cyc, blk, r;
    bit               expect_rsp, wphase, on;

    in_rng = (int'(addr) < DEPTH);
    oh = '0;
    if (in_rng) oh[addr] = 1'b1;
    busy       = (wr && VERIFY) ? 2 * BLK : BLK;
    expect_rsp = !wr || VERIFY;
    hold_cyc   = early ? 0 : hold_in;

    if (!wr) begin
      exp = in_rng ? {1'b0, (stuck ? 1'b0 : ref_mem[addr])} : 2'b10;
    end else begin
      samp = in_rng && !stuck && data;
      exp  = {(!in_rng || (samp != data)), samp};
    end
    if (expect_rsp) exp_q.push_back(exp);
    if (wr && in_rng) ref_mem[addr] = data;

    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqData = data;
    checks++;
    if (ReqReady !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle got=%b exp=1", ReqReady);
    end
    @(posedge Clock); @(negedge Clock);
    ReqValid = 1'b0;
    RspReady = early;

    for (int k = 0; k < busy; k++) begin
      blk    = k / BLK;
      r      = k % BLK;
      wphase = wr && (blk == 0);
      on     = (r >= S) && (r < S + P);
      exp_we = (wphase && on) ? oh : '0;
      exp_re = (!wphase && on) ? oh : '0;
      exp_in = wphase ? data : 1'b0;
      checks++;
      if (WriteEdge !== exp_we) begin
        errors++; $display("FAIL write_edge k=%0d got=%h exp=%h", k, WriteEdge, exp_we);
      end
      checks++;
      if (ReadEdge !== exp_re) begin
        errors++; $display("FAIL read_edge k=%0d got=%h exp=%h", k, ReadEdge, exp_re);
      end
      checks++;
      if (inputData !== exp_in) begin
        errors++; $display("FAIL input_data k=%0d got=%b exp=%b", k, inputData, exp_in);
      end
      checks++;
      if (ReqReady !== 1'b0) begin
        errors++; $display("FAIL req_ready_busy k=%0d got=%b exp=0", k, ReqReady);
      end
      checks++;
      if (RspValid !== 1'b0) begin
        errors++; $display("FAIL rsp_valid_busy k=%0d got=%b exp=0", k, RspValid);
      end
      @(posedge Clock); @(negedge Clock);
    end

    if (expect_rsp) begin
      exp = exp_q.pop_front();
      for (int d = 0; d <= hold_cyc; d++) begin
        checks++;
        if (RspValid !== 1'b1) begin
          errors++; $display("FAIL rsp_valid d=%0d got=%b exp=1", d, RspValid);
        end
        checks++;
        if ({RspErr, RspData} !== exp) begin
          errors++; $display("FAIL rsp_payload d=%0d got=%b exp=%b", d, {RspErr, RspData}, exp);
        end
        checks++;
        if (ReqReady !== 1'b0 || WriteEdge !== '0 || ReadEdge !== '0) begin
          errors++; $display("FAIL resp_quiet d=%0d ready=%b we=%h re=%h exp=0", d, ReqReady, WriteEdge, ReadEdge);
        end
        if (d == hold_cyc) RspReady = 1'b1;
        @(posedge Clock); @(negedge Clock);
      end
      RspReady = 1'b0;
    end
    checks++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1 || inputData !== 1'b0) begin
      errors++; $display("FAIL back_to_idle valid=%b ready=%b in=%b exp=0/1/0", RspValid, ReqReady, inputData);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ResetN = 1'b0; ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd1; ReqData = 1'b1;
    RspReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); @(negedge Clock);
      checks++;
      if ({ReqReady, RspValid, RspData, RspErr, inputData} !== 5'b0 ||
          WriteEdge !== '0 || ReadEdge !== '0) begin
        errors++; $display("FAIL reset_outputs c=%0d rdy=%b val=%b dat=%b err=%b in=%b we=%h re=%h exp=0",
                           c, ReqReady, RspValid, RspData, RspErr, inputData, WriteEdge, ReadEdge);
      end
    end
    ReqValid = 1'b0;
    ResetN = 1'b1;
    @(posedge Clock); @(negedge Clock);
    checks++;
    if (ReqReady !== 1'b1 || RspValid !== 1'b0) begin
      errors++; $display("FAIL reset_release rdy=%b val=%b exp=1/0", ReqReady, RspValid);
    end
  endtask

  task automatic test_write_basic();
    do_txn(1'b1, 4'd5, 1'b1, 0, 1'b0);
  endtask

  task automatic test_read_hold();
    do_txn(1'b0, 4'd5, 1'b0, 3, 1'b0);
  endtask

  task automatic test_out_of_range();
    do_txn(1'b0, 4'd13, 1'b0, 1, 1'b0);
    do_txn(1'b1, 4'd14, 1'b1, 0, 1'b0);
    do_txn(1'b0, 4'd11, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'd3; ReqData = ref_mem[3];
    @(posedge Clock); @(negedge Clock);
    ReqValid = 1'b0;
    repeat (S) begin @(posedge Clock); @(negedge Clock); end
    checks++;
    if (WriteEdge !== 12'h008) begin
      errors++; $display("FAIL mid_pulse got=%h exp=008", WriteEdge);
    end
    ResetN = 1'b0;
    @(posedge Clock); @(negedge Clock);
    checks++;
    if (WriteEdge !== '0 || ReadEdge !== '0 || inputData !== 1'b0 || RspValid !== 1'b0 || ReqReady !== 1'b0) begin
      errors++; $display("FAIL mid_reset we=%h re=%h in=%b val=%b rdy=%b exp=0",
                         WriteEdge, ReadEdge, inputData, RspValid, ReqReady);
    end
    @(posedge Clock); @(negedge Clock);
    ResetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); @(negedge Clock);
      checks++;
      if (RspValid !== 1'b0 || ReqReady !== 1'b1 || WriteEdge !== '0) begin
        errors++; $display("FAIL after_reset c=%0d val=%b rdy=%b we=%h exp=0/1/0", c, RspValid, ReqReady, WriteEdge);
      end
    end
    do_txn(1'b0, 4'd3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_readback_stuck();
    stuck = 1'b1;
    do_txn(1'b1, 4'd7, 1'b1, 1, 1'b0);
    do_txn(1'b0, 4'd7, 1'b0, 0, 1'b0);
    stuck = 1'b0;
    do_txn(1'b0, 4'd7, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 4'd0, 1'b1, 0, 1'b1);
    do_txn(1'b1, 4'd11, 1'b1, 0, 1'b1);
    do_txn(1'b0, 4'd0, 1'b0, 0, 1'b1);
    do_txn(1'b0, 4'd11, 1'b0, 0, 1'b1);
    do_txn(1'b0, 4'd15, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge Clock); @(negedge Clock); end
    end
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_write_basic();
    test_read_hold();
    test_out_of_range();
    test_reset_mid_op();
    test_readback_stuck();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL exp_q_drained got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qram_access_sequencer.md
# qram_access_sequencer

Synchronous initiator for a column of single-bit QRAM cells. Accepts read/write requests over a valid/ready handshake and decodes the address to one-hot `WriteEdge`/`ReadEdge` strobes. Drives the shared `inputData` line with setup/hold margins around each strobe and samples the shared `outputData` line. Sits between the host-side memory port and the cell array, and owns all strobe timing so that cells never see overlapping or glitching edges.

## Interface
Parameters:
- `DEPTH`, 16, number of cells (rows); min 2
- `ADDR_W`, 4, address width; must satisfy 2^ADDR_W >= DEPTH
- `SETUP_CYC`, 1, cycles `inputData` is stable before a strobe; min 1
- `PULSE_CYC`, 2, strobe high time in cycles; min 1
- `HOLD_CYC`, 1, cycles after strobe falls before the line is released or sampled data is reported; min 1

Ports:
- `Clock`  in  1  single clock, all logic on rising edge
- `ResetN`  in  1  synchronous reset, active-low
- `ReqValid`  in  1  request present
- `ReqReady`  out  1  sequencer accepts request
- `ReqWrite`  in  1  1 = write, 0 = read
- `ReqAddr`  in  ADDR_W  cell index
- `ReqData`  in  1  write bit
- `RspValid`  out  1  response present
- `RspReady`  in  1  host accepts response
- `RspData`  out  1  read bit
- `RspErr`  out  1  address error or readback mismatch
- `WriteEdge`  out  DEPTH  one-hot write strobes to cells
- `ReadEdge`  out  DEPTH  one-hot read strobes to cells
- `inputData`  out  1  shared write data line to cells
- `outputData`  in  1  shared read data line from cells

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, RESP. One down-counter, width ceil(log2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1)).
- IDLE:
  - `ReqReady`=1.
  - On `ReqValid`&&`ReqReady`, latch op, addr and data, then go to SETUP.
- SETUP:
  - Writes drive `inputData`=latched bit.
  - Reads hold `inputData`=0.
  - All strobes 0.
- PULSE:
  - Assert `WriteEdge[addr]` or `ReadEdge[addr]` only, for exactly PULSE_CYC cycles.
  - Reads sample `outputData` into the data register on the last PULSE cycle.
- HOLD:
  - Strobes 0; `inputData` unchanged.
  - After HOLD_CYC cycles: reads go to RESP; writes go to IDLE with `inputData`=0.
- RESP:
  - `RspValid`=1 with `RspData`/`RspErr` stable.
  - On `RspReady`, go to IDLE.
- Out-of-range address (`ReqAddr` >= DEPTH):
  - Full SETUP/PULSE/HOLD timing runs, but no strobe bit is set.
  - Reads respond with `RspData`=0, `RspErr`=1.
  - Writes are silently dropped.
- At most one strobe bit high in any cycle; `WriteEdge` and `ReadEdge` never high together.
- Reset values: `ReqReady`=0 while `ResetN`=0. `RspValid`, `RspData`, `RspErr`, `WriteEdge`, `ReadEdge`, `inputData` all 0. State is IDLE.
- Reset mid-operation: at the reset edge all strobes drop to 0 and the in-flight request is discarded with no response.

## Timing
- All outputs are registered except `ReqReady`, which is decoded from state==IDLE && `ResetN`.
- Request accepted at edge t0:
  - SETUP covers cycles t0+1 .. t0+SETUP_CYC.
  - Strobe is high for the next PULSE_CYC cycles.
  - HOLD follows for HOLD_CYC cycles.
- Read latency, defaults: `RspValid` is high from edge t0+4 until the edge where `RspReady` is sampled high.
- Write occupancy, defaults: `ReqReady` returns high in the cycle after edge t0+4; next accept at t0+5 or later.
- `RspReady` high before `RspValid`: ignored.
- `RspValid` held with `RspReady` low: data is held indefinitely and no new request is accepted.

## Configuration
- `QRAM_READBACK_VERIFY_EN` defined:
  - After a write's HOLD, the FSM runs a read SETUP/PULSE/HOLD on the same address.
  - Then it enters RESP with `RspData`=sampled bit and `RspErr`=(sampled != written).
  - Every write produces a response; default write latency to `RspValid` is t0+8.
- Undefined:
  - Writes produce no response.
  - `RspErr` is set only for out-of-range reads.

## Test plan
- Reset then idle: `ResetN`=0 for 3 cycles, then release. All outputs 0 during reset; `ReqReady`=1 on the first cycle after release.
- Write addr 5, data 1 (defaults): `inputData`=1 at t0+1. `WriteEdge`=16'h0020 in cycles t0+2..t0+3 only. `inputData`=0 and `ReqReady`=1 after t0+4.
- Read addr 5 with the cell model returning 1: `ReadEdge`=16'h0020 for 2 cycles. `RspValid`=1, `RspData`=1, `RspErr`=0 at t0+4. Hold `RspReady`=0 for 3 cycles and check the response stays stable and `ReqReady`=0.
- Read with `DEPTH`=12, addr 13: no strobe ever high. Response `RspData`=0, `RspErr`=1.
- Reset asserted during PULSE of a write to addr 3: `WriteEdge`=0 at the next edge and no response. Then a read of addr 3 completes normally.
- With `QRAM_READBACK_VERIFY_EN`, cell model stuck at 0, write 1 to addr 7: `WriteEdge` pulse, then `ReadEdge` pulse. Response at t0+8 with `RspData`=0, `RspErr`=1.
